// File: rtl/cmp_max_sequencer.sv
// cmp_max_sequencer
//   Finds the maximum of a frame of COUNT unsigned words by time-sharing one
//   external "A > B" comparator. Words arrive over a valid/ready stream. The
//   block keeps the running maximum and its position, and publishes the
//   result with a one-cycle done pulse at the end of each frame.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a frame (honoured in IDLE or DONE only)
//   in_valid  in   in_data carries a word
//   in_ready  out  block accepts a word this cycle (state-only)
//   in_data   in   unsigned input word
//   cmp_a     out  comparator operand A (= in_data)
//   cmp_b     out  comparator operand B (= running maximum)
//   cmp_agb   in   comparator result, cmp_a > cmp_b
//   busy      out  frame in progress (LOAD or COMPARE)
//   done      out  one-cycle pulse, max_data/max_index are fresh
//   max_data  out  maximum of the last completed frame
//   max_index out  0-based position of that maximum
module cmp_max_sequencer #(
  parameter int WIDTH = 2,
  parameter int COUNT = 4,
  parameter int IDXW  = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_agb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_data,
  output logic [IDXW-1:0]  max_index
);

  // Counter must be able to hold COUNT itself (the terminal value).
  localparam int CNTW = $clog2(COUNT + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(COUNT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPARE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [IDXW-1:0]  run_idx_q, run_idx_d;
  logic [WIDTH-1:0] max_data_q, max_data_d;
  logic [IDXW-1:0]  max_index_q, max_index_d;
  logic             accept;

  assign in_ready  = (state_q == S_LOAD) || (state_q == S_COMPARE);
  assign busy      = in_ready;
  assign done      = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign cmp_a     = in_data;
  assign cmp_b     = run_max_q;
  assign max_data  = max_data_q;
  assign max_index = max_index_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    max_data_d  = max_data_q;
    max_index_d = max_index_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          run_max_d = in_data;
          run_idx_d = '0;
          cnt_d     = CNTW'(1);
          state_d   = (COUNT == 1) ? S_DONE : S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (accept) begin
          // Strictly greater only: ties keep the earliest occurrence.
          if (cmp_agb) begin
            run_max_d = in_data;
            run_idx_d = IDXW'(cnt_q);
          end
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_d == LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Publish on entry to DONE using the post-accept running values, so the
    // final word of the frame is included and done/max_* change together.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      max_data_d  = run_max_d;
      max_index_d = run_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      max_data_q  <= '0;
      max_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      max_data_q  <= max_data_d;
      max_index_q <= max_index_d;
    end
  end

endmodule

// File: tb/tb_cmp_max_sequencer.sv
module tb_cmp_max_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with COUNT=4 ----------------
  logic       start = 1'b0, in_valid = 1'b0, in_ready, cmp_agb, busy, done;
  logic [1:0] in_data = 2'b00, cmp_a, cmp_b, max_data;
  logic [1:0] max_index;

  cmp_max_sequencer #(.WIDTH(2), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_agb(cmp_agb), .busy(busy), .done(done), .max_data(max_data),
    .max_index(max_index));

  // External magnitude comparator.
  assign cmp_agb = (cmp_a > cmp_b);

  // ---------------- DUT with COUNT=1 ----------------
  logic       u_start = 1'b0, u_in_valid = 1'b0, u_in_ready, u_cmp_agb, u_busy, u_done;
  logic [1:0] u_in_data = 2'b00, u_cmp_a, u_cmp_b, u_max_data;
  logic [0:0] u_max_index;

  cmp_max_sequencer #(.WIDTH(2), .COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(u_start), .in_valid(u_in_valid),
    .in_ready(u_in_ready), .in_data(u_in_data), .cmp_a(u_cmp_a), .cmp_b(u_cmp_b),
    .cmp_agb(u_cmp_agb), .busy(u_busy), .done(u_done), .max_data(u_max_data),
    .max_index(u_max_index));

  assign u_cmp_agb = (u_cmp_a > u_cmp_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: maximum of the frame, first occurrence wins.
  task automatic ref_max(input logic [7:0] wv, output int mx, output int ix);
    int w;
    mx = -1;
    ix = 0;
    for (int i = 0; i < 4; i++) begin
      w = int'(wv[2*i +: 2]);
      if (w > mx) begin
        mx = w;
        ix = i;
      end
    end
  endtask

  // Runs one 4-word frame starting from IDLE or DONE. Word i is wv[2i+1:2i].
  // gap = idle cycles with in_valid low before each word.
  task automatic frame4(input string tag, input logic [7:0] wv, input int gap,
                        input bit mid_start, input int emax, input int eidx);
    int cyc;
    int early_done;
    early_done = 0;
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    cyc++;
    check({tag, "_ready_after_start"}, int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        tick();
        cyc++;
        if (!busy) check({tag, "_busy_in_stall"}, int'(busy), 1);
        if (done) early_done++;
      end
      if (mid_start && i == 2) start = 1'b1;
      in_valid = 1'b1;
      in_data  = wv[2*i +: 2];
      tick();
      cyc++;
      start = 1'b0;
      if (i < 3 && done) early_done++;
    end
    in_valid = 1'b0;
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_max_data"}, int'(max_data), emax);
    check({tag, "_max_index"}, int'(max_index), eidx);
    if (gap == 0) check({tag, "_done_cycle"}, cyc, 5);
    check({tag, "_early_done"}, early_done, 0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] wv;
    int         gap;
    int         emax;
    int         eidx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int mx, ix;
    logic [7:0] rw;
    vecs[0] = '{"tie_later", 8'b11_10_11_01, 0, 3, 1};
    vecs[1] = '{"all_zero",  8'b00_00_00_00, 0, 0, 0};
    vecs[2] = '{"ramp_stall",8'b11_10_01_00, 3, 3, 3};
    vecs[3] = '{"tie_adj",   8'b00_11_11_10, 1, 3, 1};
    vecs[4] = '{"first_max", 8'b00_00_00_11, 0, 3, 0};

    // Reset state
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_max_data", int'(max_data), 0);
    check("rst_max_index", int'(max_index), 0);
    check("rst_cmp_b", int'(cmp_b), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven frames, each followed by a return to IDLE
    for (int v = 0; v < 5; v++) begin
      frame4(vecs[v].name, vecs[v].wv, vecs[v].gap, 1'b0, vecs[v].emax, vecs[v].eidx);
      tick();
      check({vecs[v].name, "_done_pulse_end"}, int'(done), 0);
      check({vecs[v].name, "_idle_ready"}, int'(in_ready), 0);
      check({vecs[v].name, "_hold_max"}, int'(max_data), vecs[v].emax);
      tick();
    end

    // Start pulsed mid-frame is ignored; then start held in DONE chains a frame
    frame4("mid_start", 8'b01_00_10_01, 0, 1'b1, 2, 1);
    frame4("back2back", 8'b10_11_00_01, 0, 1'b0, 3, 2);
    tick();

    // Asynchronous reset after 2 accepts
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 2'b11; tick();
    in_data = 2'b10; tick();
    in_valid = 1'b0;
    check("pre_rst_cmp_b", int'(cmp_b), 3);
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready", int'(in_ready), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_max_data", int'(max_data), 0);
    check("arst_max_index", int'(max_index), 0);
    check("arst_cmp_b", int'(cmp_b), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    frame4("post_rst", 8'b01_00_01_10, 0, 1'b0, 2, 0);
    tick();

    // Randomized frames against the reference model
    for (int r = 0; r < 30; r++) begin
      rw = 8'($urandom);
      ref_max(rw, mx, ix);
      frame4($sformatf("rand%0d", r), rw, int'($urandom_range(0, 2)), 1'b0, mx, ix);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    // COUNT=1 instance
    check("c1_idle_ready", int'(u_in_ready), 0);
    u_start = 1'b1; tick(); u_start = 1'b0;
    check("c1_ready", int'(u_in_ready), 1);
    u_in_valid = 1'b1; u_in_data = 2'b10; tick();
    u_in_valid = 1'b0;
    check("c1_done", int'(u_done), 1);
    check("c1_max_data", int'(u_max_data), 2);
    check("c1_max_index", int'(u_max_index), 0);
    tick();
    check("c1_done_end", int'(u_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
